multicycle_controller: RTL and testbench

//  Parametrised multi-cycle RV32I main control FSM. Successor to the combinational single-cycle decoder.

---
 rtl/multicycle_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with
// memory-ready waits, optional wait timeout, and a sticky TRAP for illegal opcodes.
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          SUPPORT_UPPER  = 1'b1,
    parameter int unsigned ALUOP_W        = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         Opcode,
    input  logic               branch_taken,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_sel,
    output logic               alu_a_pc,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               dmem_req,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic [1:0]         WBSel,
    output logic               illegal_instr,
    output logic               timeout,
    output logic [2:0]         state
);

    // Handshake: a request stays high every cycle until its ready is sampled high;
    // the cycle with ready high completes the transfer and advances the FSM.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CL_NONE, CL_R, CL_I, CL_LOAD, CL_STORE,
        CL_BRANCH, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
    } op_class_e;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e          state_q, state_d;
    op_class_e       class_q, class_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;

    logic [CNT_W:0]  cnt_inc;
    logic            limit_hit;
    op_class_e       decoded;
    logic [1:0]      alu_op2;

    function automatic op_class_e decode_op(input logic [6:0] op);
        op_class_e cl;
        cl = CL_NONE;
        case (op)
            7'b0110011: cl = CL_R;
            7'b0010011: cl = CL_I;
            7'b0000011: cl = CL_LOAD;
            7'b0100011: cl = CL_STORE;
            7'b1100011: cl = CL_BRANCH;
            7'b1101111: cl = CL_JAL;
            7'b1100111: cl = CL_JALR;
            7'b0110111: if (SUPPORT_UPPER) cl = CL_LUI;
            7'b0010111: if (SUPPORT_UPPER) cl = CL_AUIPC;
            default:    cl = CL_NONE;
        endcase
        return cl;
    endfunction

    // The wait counter is only nonzero while stalled; any state change clears it.
    always_comb begin
        cnt_inc   = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        limit_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_inc) == TIMEOUT_CYCLES);
        decoded   = decode_op(Opcode);
    end

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (limit_hit) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = (TIMEOUT_CYCLES != 0) ? cnt_inc[CNT_W-1:0] : '0;
                end
            end
            S_DECODE: begin
                class_d = decoded;
                if (decoded == CL_NONE) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (class_q)
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    CL_BRANCH:         state_d = S_FETCH;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = (class_q == CL_LOAD) ? S_WB : S_FETCH;
                end else if (limit_hit) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = (TIMEOUT_CYCLES != 0) ? cnt_inc[CNT_W-1:0] : '0;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            class_q   <= CL_NONE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobes are decoded from the registered state, so reset forces them low at once.
    always_comb begin
        imem_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 2'b00;
        alu_a_pc = 1'b0;
        ALUSrc   = 1'b0;
        alu_op2  = 2'b00;
        dmem_req = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        WBSel    = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                case (class_q)
                    CL_R:              alu_op2 = 2'b10;
                    CL_I: begin
                        alu_op2 = 2'b10;
                        ALUSrc  = 1'b1;
                    end
                    CL_LOAD, CL_STORE: ALUSrc = 1'b1;
                    CL_BRANCH: begin
                        alu_op2 = 2'b01;
                        if (branch_taken) begin
                            pc_write = 1'b1;
                            pc_sel   = 2'b01;
                        end
                    end
                    CL_JAL: begin
                        alu_a_pc = 1'b1;
                        ALUSrc   = 1'b1;
                        pc_write = 1'b1;
                        pc_sel   = 2'b01;
                    end
                    CL_JALR: begin
                        ALUSrc   = 1'b1;
                        pc_write = 1'b1;
                        pc_sel   = 2'b10;
                    end
                    CL_LUI: begin
                        alu_op2 = 2'b11;
                        ALUSrc  = 1'b1;
                    end
                    CL_AUIPC: begin
                        alu_a_pc = 1'b1;
                        ALUSrc   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                MemWrite = (class_q == CL_STORE);
            end
            S_WB: begin
                RegWrite = 1'b1;
                case (class_q)
                    CL_LOAD:         WBSel = 2'b01;
                    CL_JAL, CL_JALR: WBSel = 2'b10;
                    default:         WBSel = 2'b00;
                endcase
            end
            default: ;
        endcase
    end

    assign ALUOp         = ALUOP_W'(alu_op2);
    assign illegal_instr = illegal_q;
    assign timeout       = timeout_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: dut_a (timeout 4, upper ops legal, 3-bit ALUOp) and dut_b
// (timeout disabled, upper ops illegal) share all inputs.
module tb_multicycle_controller;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic       clk;
    logic       reset;
    logic [6:0] Opcode;
    logic       branch_taken;
    logic       imem_ready;
    logic       dmem_ready;

    logic       imem_req_a, ir_write_a, pc_write_a, alu_a_pc_a, alu_src_a;
    logic [1:0] pc_sel_a, wb_sel_a;
    logic [2:0] alu_op_a;
    logic       dmem_req_a, mem_write_a, reg_write_a, illegal_a, timeout_a;
    logic [2:0] state_a;

    logic       imem_req_b, ir_write_b, pc_write_b, alu_a_pc_b, alu_src_b;
    logic [1:0] pc_sel_b, wb_sel_b;
    logic [1:0] alu_op_b;
    logic       dmem_req_b, mem_write_b, reg_write_b, illegal_b, timeout_b;
    logic [2:0] state_b;

    logic [14:0] ctl_a, ctl_b;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        chk_b;

    multicycle_controller #(.TIMEOUT_CYCLES(4), .SUPPORT_UPPER(1'b1), .ALUOP_W(3)) dut_a (
        .clk(clk), .reset(reset), .Opcode(Opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req_a), .ir_write(ir_write_a), .pc_write(pc_write_a),
        .pc_sel(pc_sel_a), .alu_a_pc(alu_a_pc_a), .ALUSrc(alu_src_a), .ALUOp(alu_op_a),
        .dmem_req(dmem_req_a), .MemWrite(mem_write_a), .RegWrite(reg_write_a),
        .WBSel(wb_sel_a), .illegal_instr(illegal_a), .timeout(timeout_a), .state(state_a)
    );

    multicycle_controller #(.TIMEOUT_CYCLES(0), .SUPPORT_UPPER(1'b0), .ALUOP_W(2)) dut_b (
        .clk(clk), .reset(reset), .Opcode(Opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req_b), .ir_write(ir_write_b), .pc_write(pc_write_b),
        .pc_sel(pc_sel_b), .alu_a_pc(alu_a_pc_b), .ALUSrc(alu_src_b), .ALUOp(alu_op_b),
        .dmem_req(dmem_req_b), .MemWrite(mem_write_b), .RegWrite(reg_write_b),
        .WBSel(wb_sel_b), .illegal_instr(illegal_b), .timeout(timeout_b), .state(state_b)
    );

    assign ctl_a = {imem_req_a, ir_write_a, pc_write_a, pc_sel_a, alu_a_pc_a, alu_src_a,
                    alu_op_a, dmem_req_a, mem_write_a, reg_write_a, wb_sel_a};
    assign ctl_b = {imem_req_b, ir_write_b, pc_write_b, pc_sel_b, alu_a_pc_b, alu_src_b,
                    1'b0, alu_op_b, dmem_req_b, mem_write_b, reg_write_b, wb_sel_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected strobe word in the same field order as ctl_a.
    function automatic logic [14:0] c(input logic imem, input logic ir, input logic pcw,
                                      input logic [1:0] psel, input logic apc, input logic src,
                                      input logic [2:0] aop, input logic dreq, input logic mw,
                                      input logic rw, input logic [1:0] wb);
        return {imem, ir, pcw, psel, apc, src, aop, dreq, mw, rw, wb};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs already set; checks, then waits one cycle.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [14:0] ctl);
        #1;
        check({tag, "_state"}, 32'(state_a), 32'(st));
        check({tag, "_ctl"}, 32'(ctl_a), 32'(ctl));
        if (chk_b) check({tag, "_b_state"}, 32'(state_b), 32'(st));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [14:0] f_rdy, f_wait;

    initial begin
        f_rdy  = c(1, 1, 1, 2'b00, 0, 0, 3'b000, 0, 0, 0, 2'b00);
        f_wait = c(1, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 2'b00);
        chk_b = 1'b1;
        reset = 1'b1;
        Opcode = 7'd0;
        branch_taken = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_ctl", 32'(ctl_a), 32'd0);
        check("rst_illegal", 32'(illegal_a), 32'd0);
        check("rst_timeout", 32'(timeout_a), 32'd0);
        check("rst_b_ctl", 32'(ctl_b), 32'd0);
        reset = 1'b0;
        cyc("idle", 3'd0, '0);

        // add, zero-wait memory: 4 cycles
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        Opcode = OP_R;
        cyc("add_fetch", 3'd1, f_rdy);
        cyc("add_dec", 3'd2, '0);
        cyc("add_exec", 3'd3, c(0, 0, 0, 2'b00, 0, 0, 3'b010, 0, 0, 0, 2'b00));
        cyc("add_wb", 3'd5, c(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 1, 2'b00));

        // lw with three wait cycles; ready on the 4th cycle meets the limit of 4
        Opcode = OP_LD;
        cyc("lw_fetch", 3'd1, f_rdy);
        cyc("lw_dec", 3'd2, '0);
        cyc("lw_exec", 3'd3, c(0, 0, 0, 2'b00, 0, 1, 3'b000, 0, 0, 0, 2'b00));
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("lw_mem_wait", 3'd4, c(0, 0, 0, 2'b00, 0, 0, 3'b000, 1, 0, 0, 2'b00));
        dmem_ready = 1'b1;
        cyc("lw_mem_done", 3'd4, c(0, 0, 0, 2'b00, 0, 0, 3'b000, 1, 0, 0, 2'b00));
        cyc("lw_wb", 3'd5, c(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 1, 2'b01));
        check("lw_no_timeout", 32'(timeout_a), 32'd0);

        // sw: 4 cycles, back to FETCH after MEM
        Opcode = OP_ST;
        cyc("sw_fetch", 3'd1, f_rdy);
        cyc("sw_dec", 3'd2, '0);
        cyc("sw_exec", 3'd3, c(0, 0, 0, 2'b00, 0, 1, 3'b000, 0, 0, 0, 2'b00));
        cyc("sw_mem", 3'd4, c(0, 0, 0, 2'b00, 0, 0, 3'b000, 1, 1, 0, 2'b00));

        // beq taken then not taken: 3 cycles each
        Opcode = OP_BR;
        cyc("beqt_fetch", 3'd1, f_rdy);
        cyc("beqt_dec", 3'd2, '0);
        branch_taken = 1'b1;
        cyc("beqt_exec", 3'd3, c(0, 0, 1, 2'b01, 0, 0, 3'b001, 0, 0, 0, 2'b00));
        branch_taken = 1'b0;
        cyc("beqn_fetch", 3'd1, f_rdy);
        cyc("beqn_dec", 3'd2, '0);
        cyc("beqn_exec", 3'd3, c(0, 0, 0, 2'b00, 0, 0, 3'b001, 0, 0, 0, 2'b00));

        Opcode = OP_JAL;
        cyc("jal_fetch", 3'd1, f_rdy);
        cyc("jal_dec", 3'd2, '0);
        cyc("jal_exec", 3'd3, c(0, 0, 1, 2'b01, 1, 1, 3'b000, 0, 0, 0, 2'b00));
        cyc("jal_wb", 3'd5, c(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 1, 2'b10));

        Opcode = OP_JALR;
        cyc("jalr_fetch", 3'd1, f_rdy);
        cyc("jalr_dec", 3'd2, '0);
        cyc("jalr_exec", 3'd3, c(0, 0, 1, 2'b10, 0, 1, 3'b000, 0, 0, 0, 2'b00));
        cyc("jalr_wb", 3'd5, c(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 1, 2'b10));

        Opcode = OP_I;
        cyc("addi_fetch", 3'd1, f_rdy);
        cyc("addi_dec", 3'd2, '0);
        cyc("addi_exec", 3'd3, c(0, 0, 0, 2'b00, 0, 1, 3'b010, 0, 0, 0, 2'b00));
        cyc("addi_wb", 3'd5, c(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 1, 2'b00));

        // lui: legal on dut_a, illegal on dut_b
        Opcode = OP_LUI;
        cyc("lui_fetch", 3'd1, f_rdy);
        cyc("lui_dec", 3'd2, '0);
        chk_b = 1'b0;
        #1;
        check("lui_b_state", 32'(state_b), 32'd6);
        check("lui_b_illegal", 32'(illegal_b), 32'd1);
        check("lui_b_ctl", 32'(ctl_b), 32'd0);
        check("lui_a_illegal", 32'(illegal_a), 32'd0);
        cyc("lui_exec", 3'd3, c(0, 0, 0, 2'b00, 0, 1, 3'b011, 0, 0, 0, 2'b00));
        cyc("lui_wb", 3'd5, c(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 1, 2'b00));

        Opcode = OP_AUIPC;
        cyc("auipc_fetch", 3'd1, f_rdy);
        cyc("auipc_dec", 3'd2, '0);
        cyc("auipc_exec", 3'd3, c(0, 0, 0, 2'b00, 1, 1, 3'b000, 0, 0, 0, 2'b00));
        cyc("auipc_wb", 3'd5, c(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 1, 2'b00));
        cyc("auipc_next", 3'd1, f_rdy);
        check("b_trap_held", 32'(state_b), 32'd6);

        // Illegal opcode: TRAP after DECODE, strobes stay low, reset clears flag
        do_reset();
        chk_b = 1'b1;
        Opcode = 7'b1111111;
        cyc("ill_idle", 3'd0, '0);
        cyc("ill_fetch", 3'd1, f_rdy);
        cyc("ill_dec", 3'd2, '0);
        for (int i = 0; i < 20; i++) cyc("ill_trap", 3'd6, '0);
        #1;
        check("ill_flag", 32'(illegal_a), 32'd1);
        check("ill_no_timeout", 32'(timeout_a), 32'd0);
        reset = 1'b1;
        #1;
        check("ill_rst_flag", 32'(illegal_a), 32'd0);
        check("ill_rst_state", 32'(state_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // imem_ready stuck low: dut_a traps after 4 wait cycles, dut_b waits forever
        imem_ready = 1'b0;
        Opcode = OP_R;
        cyc("to_idle", 3'd0, '0);
        for (int i = 0; i < 4; i++) cyc("to_fetch_wait", 3'd1, f_wait);
        chk_b = 1'b0;
        #1;
        check("to_state", 32'(state_a), 32'd6);
        check("to_flag", 32'(timeout_a), 32'd1);
        check("to_illegal", 32'(illegal_a), 32'd0);
        check("to_ctl", 32'(ctl_a), 32'd0);
        check("to_b_state", 32'(state_b), 32'd1);
        check("to_b_flag", 32'(timeout_b), 32'd0);
        for (int i = 0; i < 8; i++) @(negedge clk);
        #1;
        check("to_b_still_wait", 32'(state_b), 32'd1);
        check("to_held", 32'(state_a), 32'd6);
        reset = 1'b1;
        #1;
        check("to_rst_flag", 32'(timeout_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted while in MEM: outputs drop immediately
        chk_b = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        Opcode = OP_LD;
        cyc("rm_idle", 3'd0, '0);
        cyc("rm_fetch", 3'd1, f_rdy);
        cyc("rm_dec", 3'd2, '0);
        cyc("rm_exec", 3'd3, c(0, 0, 0, 2'b00, 0, 1, 3'b000, 0, 0, 0, 2'b00));
        #1;
        check("rm_in_mem", 32'(state_a), 32'd4);
        check("rm_dreq", 32'(dmem_req_a), 32'd1);
        reset = 1'b1;
        #1;
        check("rm_rst_state", 32'(state_a), 32'd0);
        check("rm_rst_ctl", 32'(ctl_a), 32'd0);
        check("rm_rst_b_ctl", 32'(ctl_b), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
